// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMemory port between the pipeline MEM stage and a loader.
// Optional saturating grant/stall counters are built when ARB_STATS_EN is defined.
module dmem_port_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] P_Address,
    input  logic [31:0] P_WriteData,
    input  logic        P_MemWrite,
    input  logic        P_MemRead,
    output logic [31:0] P_ReadData,
    output logic        Stall,
    input  logic        L_Req,
    input  logic        L_Write,
    input  logic [31:0] L_Address,
    input  logic [31:0] L_WriteData,
    output logic        L_Gnt,
    output logic [31:0] L_ReadData,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    output logic        Mem_MemWrite,
    output logic        Mem_MemRead,
    input  logic [31:0] Mem_ReadData,
    output logic        Owner,
    output logic [15:0] Stat_Grants,
    output logic [15:0] Stat_Stalls
);

    localparam int unsigned CntW  = 4;
    localparam int unsigned StatW = 16;

    typedef enum logic [1:0] {
        S_PIPE  = 2'd0,
        S_LOAD  = 2'd1,
        S_YIELD = 2'd2
    } arbStateT;

    arbStateT            stateQ, stateD;
    logic [CntW-1:0]     burstQ, burstD;
    logic [CntW-1:0]     waitQ, waitD;
    logic                ownerQ;
    logic                pAccess;
    logic                gnt;
    logic                stallInt;

    assign pAccess  = P_MemRead | P_MemWrite;
    assign gnt      = ownerQ & L_Req;
    assign stallInt = Rst & ownerQ & pAccess;

    // State, counters and the owner bit
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateQ <= S_PIPE;
            burstQ <= '0;
            waitQ  <= '0;
            ownerQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            burstQ <= burstD;
            waitQ  <= waitD;
            ownerQ <= (stateD == S_LOAD);
        end
    end

    // Next-state: wait_cnt only runs while the loader is blocked in S_PIPE
    always_comb begin
        stateD = stateQ;
        burstD = burstQ;
        waitD  = waitQ;
        unique case (stateQ)
            S_PIPE: begin
                burstD = '0;
                if (L_Req && !pAccess) begin
                    stateD = S_LOAD;
                    waitD  = '0;
                end else if (L_Req) begin
                    if (waitQ == CntW'(MAX_WAIT - 1)) begin
                        stateD = S_LOAD;
                        waitD  = '0;
                    end else begin
                        waitD = waitQ + CntW'(1);
                    end
                end else begin
                    waitD = '0;
                end
            end
            S_LOAD: begin
                waitD = '0;
                if (!L_Req) begin
                    stateD = S_YIELD;
                    burstD = '0;
                end else if (burstQ == CntW'(MAX_BURST - 1)) begin
                    stateD = S_YIELD;
                    burstD = '0;
                end else begin
                    burstD = burstQ + CntW'(1);
                end
            end
            S_YIELD: begin
                stateD = S_PIPE;
                burstD = '0;
                waitD  = '0;
            end
            default: begin
                stateD = S_PIPE;
                burstD = '0;
                waitD  = '0;
            end
        endcase
    end

    // Port mux; strobes are forced low while reset is asserted
    always_comb begin
        if (ownerQ) begin
            Mem_Address   = L_Address;
            Mem_WriteData = L_WriteData;
            Mem_MemWrite  = Rst & L_Req & L_Write;
            Mem_MemRead   = Rst & L_Req & ~L_Write;
        end else begin
            Mem_Address   = P_Address;
            Mem_WriteData = P_WriteData;
            Mem_MemWrite  = Rst & P_MemWrite;
            Mem_MemRead   = Rst & P_MemRead;
        end
    end

    assign P_ReadData = Mem_ReadData;
    assign L_ReadData = Mem_ReadData;
    assign Stall      = stallInt;
    assign L_Gnt      = Rst & gnt;
    assign Owner      = ownerQ;

`ifdef ARB_STATS_EN
    logic [StatW-1:0] grantCntQ;
    logic [StatW-1:0] stallCntQ;

    // Saturating activity counters, cleared only by reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            grantCntQ <= '0;
            stallCntQ <= '0;
        end else begin
            if (gnt && (grantCntQ != {StatW{1'b1}})) begin
                grantCntQ <= grantCntQ + StatW'(1);
            end
            if (stallInt && (stallCntQ != {StatW{1'b1}})) begin
                stallCntQ <= stallCntQ + StatW'(1);
            end
        end
    end

    assign Stat_Grants = grantCntQ;
    assign Stat_Stalls = stallCntQ;
`else
    assign Stat_Grants = '0;
    assign Stat_Stalls = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios then random traffic
// against a transaction-level model of the port sharing rules.
module tb_dmem_port_arbiter;

    localparam int unsigned MaxBurst = 4;
    localparam int unsigned MaxWait  = 8;

    logic        Clk;
    logic        Rst;
    logic [31:0] P_Address, P_WriteData, P_ReadData;
    logic        P_MemWrite, P_MemRead, Stall;
    logic        L_Req, L_Write, L_Gnt;
    logic [31:0] L_Address, L_WriteData, L_ReadData;
    logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
    logic        Mem_MemWrite, Mem_MemRead, Owner;
    logic [15:0] Stat_Grants, Stat_Stalls;

    dmem_port_arbiter #(.MAX_BURST(MaxBurst), .MAX_WAIT(MaxWait)) dut (
        .Clk(Clk), .Rst(Rst),
        .P_Address(P_Address), .P_WriteData(P_WriteData),
        .P_MemWrite(P_MemWrite), .P_MemRead(P_MemRead),
        .P_ReadData(P_ReadData), .Stall(Stall),
        .L_Req(L_Req), .L_Write(L_Write), .L_Address(L_Address),
        .L_WriteData(L_WriteData), .L_Gnt(L_Gnt), .L_ReadData(L_ReadData),
        .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
        .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
        .Mem_ReadData(Mem_ReadData), .Owner(Owner),
        .Stat_Grants(Stat_Grants), .Stat_Stalls(Stat_Stalls)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // DataMemory stand-in: combinational read, clocked write
    logic [31:0] memArr [64];
    assign Mem_ReadData = memArr[Mem_Address[7:2]];
    always @(posedge Clk) if (Mem_MemWrite) memArr[Mem_Address[7:2]] <= Mem_WriteData;

    typedef struct {
        logic        owner, stall, gnt, memW, memR;
        logic [31:0] memA, memWd;
        bit          pRdV;
        logic [31:0] pRd;
        bit          lRdV;
        logic [31:0] lRd;
    } expT;

    expT expQ[$];
    int  errors = 0;
    int  checks = 0;

    // Reference state: what the data memory holds and who may use the port
    logic [31:0] refMem [64];
    bit  mOwns, mYield, mPrevStall, mPrevGnt;
    int  mBurst, mWait, mGrants, mStalls;

    logic [31:0] nPA, nPWd, nLA, nLWd;
    logic        nPR, nPW, nLReq, nLW;
    logic        obsOwner, obsGnt;
    logic [31:0] obsPRd;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] randAddr();
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 63));
        return {24'b0, idx, 2'b00};
    endfunction

    task automatic modelReset();
        mOwns = 0; mYield = 0; mPrevStall = 0; mPrevGnt = 0;
        mBurst = 0; mWait = 0; mGrants = 0; mStalls = 0;
    endtask

    task automatic setIdle();
        nPR = 0; nPW = 0; nLReq = 0; nLW = 0;
        nPA = 32'h0; nPWd = 32'h0; nLA = 32'h0; nLWd = 32'h0;
    endtask

    task automatic applyInputs();
        P_Address = nPA; P_WriteData = nPWd; P_MemRead = nPR; P_MemWrite = nPW;
        L_Req = nLReq; L_Write = nLW; L_Address = nLA; L_WriteData = nLWd;
    endtask

    // One clock: drive inputs, predict this cycle's outputs, advance the model
    task automatic step();
        expT e;
        bit  pAcc;
        @(posedge Clk);
        #1;
        applyInputs();
        pAcc    = nPR | nPW;
        e.owner = mOwns;
        e.stall = mOwns & pAcc;
        e.gnt   = mOwns & nLReq;
        if (mOwns) begin
            e.memA = nLA; e.memWd = nLWd; e.memW = nLReq & nLW; e.memR = nLReq & ~nLW;
        end else begin
            e.memA = nPA; e.memWd = nPWd; e.memW = nPW; e.memR = nPR;
        end
        e.pRdV = !mOwns && nPR;
        e.pRd  = refMem[nPA[7:2]];
        e.lRdV = e.gnt && !nLW;
        e.lRd  = refMem[nLA[7:2]];
        expQ.push_back(e);
        if (!mOwns && nPW) refMem[nPA[7:2]] = nPWd;
        if (e.gnt && nLW)  refMem[nLA[7:2]] = nLWd;
        if (e.gnt   && mGrants < 65535) mGrants++;
        if (e.stall && mStalls < 65535) mStalls++;
        if (mOwns) begin
            if (!nLReq) begin
                mOwns = 0; mYield = 1; mBurst = 0;
            end else begin
                mBurst++;
                if (mBurst == int'(MaxBurst)) begin
                    mOwns = 0; mYield = 1; mBurst = 0;
                end
            end
        end else if (mYield) begin
            mYield = 0; mWait = 0;
        end else if (nLReq) begin
            if (!pAcc) begin
                mOwns = 1; mWait = 0;
            end else begin
                mWait++;
                if (mWait == int'(MaxWait)) begin
                    mOwns = 1; mWait = 0;
                end
            end
        end else begin
            mWait = 0;
        end
        mPrevStall = e.stall;
        mPrevGnt   = e.gnt;
        #1;
        obsOwner = Owner; obsGnt = L_Gnt; obsPRd = P_ReadData;
    endtask

    // Random traffic that honours the hold rules of both requesters
    task automatic randNext();
        int r;
        if (!mPrevStall) begin
            r    = $urandom_range(0, 9);
            nPR  = (r < 3);
            nPW  = (r >= 3 && r < 6);
            nPA  = randAddr();
            nPWd = $urandom;
        end
        if (!(nLReq && !mPrevGnt)) begin
            nLReq = ($urandom_range(0, 9) < (nLReq ? 8 : 3));
            nLW   = 1'($urandom_range(0, 1));
            nLA   = randAddr();
            nLWd  = $urandom;
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle
    expT mon;
    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            check32("ctrl{owner,stall,gnt,wr,rd}",
                    {27'b0, Owner, Stall, L_Gnt, Mem_MemWrite, Mem_MemRead},
                    {27'b0, mon.owner, mon.stall, mon.gnt, mon.memW, mon.memR});
            check32("mem_addr", Mem_Address, mon.memA);
            check32("mem_wdata", Mem_WriteData, mon.memWd);
            if (mon.pRdV) check32("p_rdata", P_ReadData, mon.pRd);
            if (mon.lRdV) check32("l_rdata", L_ReadData, mon.lRd);
        end
    end

    initial begin
        logic [14:0] pat;
        int          grants;
        int          firstOwn;
        logic [31:0] v;

        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            memArr[i] = v;
            refMem[i] = v;
        end
        memArr[4] = 32'hDEADBEEF;
        refMem[4] = 32'hDEADBEEF;
        modelReset();

        // Reset: strobes held low even with both requesters active
        Rst = 1'b0;
        setIdle();
        nPR = 1; nPA = 32'h10; nLReq = 1; nLA = 32'h20;
        applyInputs();
        #3;
        check32("reset_outs{owner,gnt,stall,wr,rd}",
                {27'b0, Owner, L_Gnt, Stall, Mem_MemWrite, Mem_MemRead}, 32'h0);
        check32("reset_stats", {Stat_Grants, Stat_Stalls}, 32'h0);
        @(posedge Clk);
        #1;
        setIdle();
        applyInputs();
        Rst = 1'b1;

        // Pipeline lw with loader idle
        nPR = 1; nPA = 32'h10;
        step();
        check32("s1_prdata", obsPRd, 32'hDEADBEEF);
        check32("s1_owner", {31'b0, obsOwner}, 32'h0);
        setIdle();
        step();

        // Single loader write, then pipeline reads it back
        nLReq = 1; nLW = 1; nLA = 32'h40; nLWd = 32'h1234;
        step();
        step();
        check32("s2_owner_gnt", {30'b0, obsOwner, obsGnt}, 32'h3);
        nLReq = 0;
        repeat (3) step();
        nPR = 1; nPA = 32'h40;
        step();
        check32("s2_readback", obsPRd, 32'h1234);
        setIdle();
        step();

        // Ten-access loader burst with the pipeline idle
        grants = 0;
        pat    = '0;
        nLReq = 1; nLW = 0; nLA = randAddr();
        for (int c = 0; c < 40 && grants < 10; c++) begin
            if (mPrevGnt) nLA = randAddr();
            step();
            pat = {pat[13:0], obsGnt};
            if (obsGnt) grants++;
        end
        check32("s3_grants", 32'(grants), 32'd10);
        check32("s3_pattern", {17'b0, pat}, {17'b0, 15'b011110011110011});
        setIdle();
        repeat (3) step();

        // Pipeline busy every cycle: loader forced in after MAX_WAIT blocked cycles
        firstOwn = -1;
        nLReq = 1; nLW = 1; nLA = randAddr(); nLWd = $urandom;
        for (int c = 0; c < 30; c++) begin
            if (!mPrevStall) begin
                nPW = 1; nPR = 0; nPA = randAddr(); nPWd = $urandom;
            end
            if (mPrevGnt) begin
                nLA = randAddr(); nLWd = $urandom;
            end
            step();
            if (obsOwner && firstOwn < 0) firstOwn = c;
        end
        check32("s4_blocked_cycles", 32'(firstOwn), 32'(MaxWait));
        setIdle();
        repeat (3) step();

        // Asynchronous reset in the middle of a burst
        nLReq = 1; nLW = 1; nLA = 32'h80; nLWd = 32'hA5A5_0001;
        step();
        step();
        check32("rst_pre_owner", {31'b0, obsOwner}, 32'h1);
        @(posedge Clk);
        #1;
        nPW = 1; nPA = 32'h84; nPWd = 32'hBAD0_BAD0;
        applyInputs();
        Rst = 1'b0;
        #1;
        check32("rst_mid_outs{owner,gnt,wr,rd,stall}",
                {27'b0, Owner, L_Gnt, Mem_MemWrite, Mem_MemRead, Stall}, 32'h0);
        @(posedge Clk);
        #1;
        setIdle();
        applyInputs();
        Rst = 1'b1;
        modelReset();
        nPR = 1; nPA = 32'h84;
        step();
        check32("rst_after_owner", {31'b0, obsOwner}, 32'h0);
        setIdle();
        step();

        // Random mixed traffic
        for (int c = 0; c < 1500; c++) begin
            randNext();
            step();
        end
        setIdle();
        repeat (3) step();
        @(posedge Clk);
        #2;

`ifdef ARB_STATS_EN
        check32("stat_grants", {16'b0, Stat_Grants}, 32'(mGrants));
        check32("stat_stalls", {16'b0, Stat_Stalls}, 32'(mStalls));
`else
        check32("stat_grants_tied", {16'b0, Stat_Grants}, 32'h0);
        check32("stat_stalls_tied", {16'b0, Stat_Stalls}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single DataMemory port between two requesters: the pipeline MEM stage (P) and a program/data loader (L, a bench or DMA-style loader).
- Sits between the MEM-stage control/address signals and the DataMemory instance.
- Raises Stall to freeze the pipeline whenever the loader owns the port and the MEM stage needs it.
- Bounds loader bursts, and the loader's wait time, so neither side starves.

Parameters:
- MAX_BURST, 4: maximum consecutive loader accesses before a forced yield to the pipeline (1..15).
- MAX_WAIT, 8: cycles a pending loader request may be blocked by pipeline accesses before a forced takeover (1..15).

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset (Rst=0 resets)
- P_Address  in  32  MEM-stage address (ALU result)
- P_WriteData  in  32  MEM-stage store data
- P_MemWrite  in  1  MEM-stage write enable
- P_MemRead  in  1  MEM-stage read enable
- P_ReadData  out  32  read data returned to MEM/WB
- Stall  out  1  freeze PC and all pipeline registers this cycle
- L_Req  in  1  loader request, held until granted
- L_Write  in  1  1=write, 0=read
- L_Address  in  32  loader address
- L_WriteData  in  32  loader write data
- L_Gnt  out  1  loader access performed this cycle
- L_ReadData  out  32  read data, valid when L_Gnt=1 and L_Write=0
- Mem_Address  out  32  to DataMemory
- Mem_WriteData  out  32  to DataMemory
- Mem_MemWrite  out  1  to DataMemory
- Mem_MemRead  out  1  to DataMemory
- Mem_ReadData  in  32  from DataMemory (combinational read)
- Owner  out  1  0=pipeline, 1=loader (registered state bit)
- Stat_Grants  out  16  optional-feature counter
- Stat_Stalls  out  16  optional-feature counter

Behaviour:
- P_Access = P_MemRead | P_MemWrite.
- State register values: S_PIPE, S_LOAD, S_YIELD. All state and counters update on rising Clk.
- Reset (Rst=0, asynchronous): state=S_PIPE, burst_cnt=0, wait_cnt=0, Owner=0, stats=0.
- During reset: Stall=0, L_Gnt=0, Mem_MemWrite=0, Mem_MemRead=0.
- Deasserting reset mid-burst returns to S_PIPE with no loader access replayed.
- Port mux (combinational, zero added latency):
  - Owner=0: Mem_* = P_*.
  - Owner=1: Mem_Address=L_Address, Mem_WriteData=L_WriteData, Mem_MemWrite=L_Req&L_Write, Mem_MemRead=L_Req&~L_Write.
  - P_ReadData and L_ReadData both equal Mem_ReadData at all times.
- S_PIPE:
  - Stall=0, L_Gnt=0.
  - If L_Req & ~P_Access: go to S_LOAD, wait_cnt=0.
  - Else if L_Req & P_Access: wait_cnt+1. When wait_cnt==MAX_WAIT-1, go to S_LOAD instead (forced takeover), wait_cnt=0.
  - Else (no L_Req): wait_cnt=0.
- S_LOAD:
  - L_Gnt=L_Req. Stall=P_Access. The pipeline's access is suppressed and replays after release, because its registers are frozen.
  - Each granted cycle increments burst_cnt.
  - Go to S_YIELD, burst_cnt=0, when L_Req=0, or when a grant occurs with burst_cnt==MAX_BURST-1.
- S_YIELD:
  - Identical to S_PIPE for the mux; L_Req is ignored.
  - Exactly one cycle, then S_PIPE with wait_cnt=0.
  - Guarantees any stalled MEM access completes.
- Owner=1 only in S_LOAD.
- Loader handshake: L_Req/L_Write/L_Address/L_WriteData must stay stable until L_Gnt. The loader may change them the cycle after L_Gnt. Back-to-back grants are allowed within a burst.
- Stall is combinational from Owner and P_Access. It never asserts in S_PIPE or S_YIELD.
- Simultaneous first-cycle contention (L_Req and P_Access both rise in S_PIPE): the pipeline wins.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Stat_Grants counts L_Gnt cycles; saturates at 16'hFFFF.
  - Stat_Stalls counts Stall cycles; saturates at 16'hFFFF.
  - Both cleared only by reset.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Idle loader, pipeline lw at P_Address=0x10 with Mem_ReadData=0xDEADBEEF -> P_ReadData=0xDEADBEEF same cycle, Stall=0, Owner=0 throughout.
- L_Req write of 0x1234 to 0x40 while P_Access=0 -> Owner=1 next cycle, L_Gnt=1 that cycle, Mem_MemWrite=1 with Mem_Address=0x40, then S_YIELD, then S_PIPE.
- Loader holds L_Req for 10 accesses, pipeline idle, MAX_BURST=4 -> grants arrive in runs of 4, each run separated by 1 yield cycle plus 1 S_PIPE cycle.
- Pipeline P_Access=1 continuously, L_Req raised, MAX_WAIT=8 -> Owner=1 after 8 blocked cycles. Stall=1 during grant cycles; in the S_YIELD cycle the pipeline sw reaches Mem_MemWrite with Stall=0.
- Rst pulsed low for 1 cycle mid-burst -> Owner=0, L_Gnt=0, Mem_MemWrite=0 immediately (asynchronous), state=S_PIPE after release.
- With ARB_STATS_EN and the scenario-4 traffic -> Stat_Grants and Stat_Stalls match bench counts exactly. A preload of 16'hFFFF does not wrap.
